// File: rtl/tcam_pkg.sv
// Shared types and constants for the TCAM search-result response path.
package tcam_pkg;

  localparam int IDX_W = 6;
  localparam int RD_W  = 5;
  localparam int XLEN  = 64;

  // Value returned to the core when no TCAM entry matched.
  localparam logic [XLEN-1:0] MISS_DATA = '1;

  // One queued search result as it leaves the priority encoder.
  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] index;
    logic [RD_W-1:0]  rd;
  } result_t;

  // Turns a result into the 64-bit RoCC response word; the index is
  // meaningless on a miss, so it is dropped there.
  function automatic logic [XLEN-1:0] format_result(input result_t r);
    logic [XLEN-1:0] data;
    if (r.hit) begin
      data = {{(XLEN-IDX_W){1'b0}}, r.index};
    end else begin
      data = MISS_DATA;
    end
    return data;
  endfunction

endpackage

// File: rtl/tcam_resp_fifo.sv
// Small in-order result FIFO. Handshake on both sides is plain valid/ready:
// a transfer happens on a rising edge where valid and ready are both high,
// and ready never looks at the other side's valid/ready in the same cycle.
module tcam_resp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [11:0]
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_push_valid,
  output logic o_push_ready,
  input  T     i_push_data,
  output logic o_pop_valid,
  input  logic i_pop_ready,
  output T     o_pop_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle,
  // which keeps push_ready independent of pop_ready.
  assign o_push_ready = (r_count < OCC_W'(DEPTH));
  assign o_pop_valid  = (r_count != '0);
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = o_pop_valid && i_pop_ready;

  // Head is forced to zero when empty so stale storage is never visible.
  assign o_pop_data   = o_pop_valid ? r_mem[r_rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  // Storage write; contents need no reset because occupancy gates them.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/tcam_resp_queue.sv
// Buffers TCAM search results toward the RoCC response channel and keeps
// saturating search/hit statistics.
module tcam_resp_queue
  import tcam_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_hit,
  input  logic [IDX_W-1:0] in_index,
  input  logic [RD_W-1:0]  in_rd,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [RD_W-1:0]  resp_rd,
  output logic [XLEN-1:0]  resp_data,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] search_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  result_t          w_in_res;
  result_t          w_head;
  logic             w_accept;
  logic [CNT_W-1:0] r_search_cnt;
  logic [CNT_W-1:0] r_hit_cnt;

  assign w_in_res.hit   = in_hit;
  assign w_in_res.index = in_index;
  assign w_in_res.rd    = in_rd;
  assign w_accept       = in_valid && in_ready;

  tcam_resp_fifo #(
    .DEPTH (DEPTH),
    .T     (result_t)
  ) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_push_valid (in_valid),
    .o_push_ready (in_ready),
    .i_push_data  (w_in_res),
    .o_pop_valid  (resp_valid),
    .i_pop_ready  (resp_ready),
    .o_pop_data   (w_head)
  );

  assign resp_rd   = w_head.rd;
  assign resp_data = resp_valid ? format_result(w_head) : '0;

  // Statistics: clear wins over a same-cycle accept, and both counters
  // stick at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset_n || clear_stats) begin
      r_search_cnt <= '0;
      r_hit_cnt    <= '0;
    end else if (w_accept) begin
      if (r_search_cnt != '1)         r_search_cnt <= r_search_cnt + 1'b1;
      if (in_hit && r_hit_cnt != '1)  r_hit_cnt    <= r_hit_cnt + 1'b1;
    end
  end

  assign search_cnt = r_search_cnt;
  assign hit_cnt    = r_hit_cnt;

endmodule
